trace_cmd_ctrl: RTL and testbench

TRACE_CMD_CTRL -- requirements
Module: trace_cmd_ctrl

---
 rtl/trace_cmd_if.sv | 28 ++
 rtl/trace_cmd_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_trace_cmd_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_cmd_if.sv
// Signal bundle between the trace command controller and its UART receiver/transmitter,
// packet source and trace front end.
interface trace_cmd_if;
    logic       rxStrobe;
    logic [7:0] rxByte;
    logic       rxErr;
    logic       pktReady;
    logic [7:0] pktByte;
    logic       pktNext;
    logic       txFree;
    logic       txTransmit;
    logic [7:0] txByte;
    logic       sync;
    logic       ovf;
    logic [2:0] width;
    logic       traceEn;
    logic       cmdErr;

    modport slave (
        input  rxStrobe, rxByte, rxErr, pktReady, pktByte, txFree, sync, ovf,
        output pktNext, txTransmit, txByte, width, traceEn, cmdErr
    );

    modport master (
        output rxStrobe, rxByte, rxErr, pktReady, pktByte, txFree, sync, ovf,
        input  pktNext, txTransmit, txByte, width, traceEn, cmdErr
    );
endinterface

// File: rtl/trace_cmd_ctrl.sv
// UART command parser for the trace port plus a byte arbiter that shares the UART
// transmitter between command replies and forwarded trace packet bytes.
module trace_cmd_ctrl #(
    parameter int unsigned CMD_TIMEOUT = 48000,
    parameter logic [2:0]  RESET_WIDTH = 3'd4
) (
    input  logic       clkOut,
    input  logic       rst,
    trace_cmd_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GET_ARG = 1'b1;
    localparam logic [7:0] CH_E       = 8'h45;
    localparam logic [7:0] CH_D       = 8'h44;
    localparam logic [7:0] CH_S       = 8'h53;
    localparam logic [7:0] CH_W       = 8'h57;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] STAT_HDR   = 8'hA5;
    localparam int         CNT_W      = $clog2(CMD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_TIMEOUT - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [8:0]       r_q0;
    logic [8:0]       r_q1;
    logic [1:0]       r_qCnt;
    logic             r_ovfSticky;
    logic             r_traceEn;
    logic [2:0]       r_width;
    logic             r_txTransmit;
    logic [7:0]       r_txByte;
    logic             r_txIsStatus;
    logic             r_pktNext;
    logic             r_cmdErr;

    logic [0:0]       w_stateNext;
    logic             w_cntClr;
    logic             w_cntInc;
    logic             w_err;
    logic             w_setEn;
    logic             w_clrEn;
    logic             w_setWidth;
    logic [1:0]       w_pushN;
    logic [8:0]       w_push0;
    logic [8:0]       w_push1;
    logic [7:0]       w_status;
    logic             w_qEmpty;
    logic             w_widthOk;
    logic             w_canIssue;
    logic             w_sendReply;
    logic             w_sendPkt;

    assign w_qEmpty  = (r_qCnt == 2'd0);
    assign w_status  = {r_traceEn, bus.sync, r_ovfSticky, 2'b00, r_width};
    assign w_widthOk = (bus.rxByte == 8'd1) || (bus.rxByte == 8'd2) || (bus.rxByte == 8'd4);

    // Queue entries carry a status tag so the sticky overflow flag clears on the right byte.
    // Replies are only pushed into an empty queue, so push and pop never coincide.
    always_comb begin
        w_stateNext = r_state;
        w_cntClr    = 1'b0;
        w_cntInc    = 1'b0;
        w_err       = 1'b0;
        w_setEn     = 1'b0;
        w_clrEn     = 1'b0;
        w_setWidth  = 1'b0;
        w_pushN     = 2'd0;
        w_push0     = 9'h000;
        w_push1     = 9'h000;
        if (bus.rxErr) begin
            w_stateNext = ST_IDLE;
            w_err       = 1'b1;
        end else if (r_state == ST_IDLE) begin
            if (bus.rxStrobe) begin
                if (bus.rxByte == CH_W) begin
                    w_stateNext = ST_GET_ARG;
                    w_cntClr    = 1'b1;
                end else if (!w_qEmpty) begin
                    w_err = 1'b1;
                end else begin
                    case (bus.rxByte)
                        CH_E: begin
                            w_setEn = 1'b1;
                            w_pushN = 2'd1;
                            w_push0 = {1'b0, ACK};
                        end
                        CH_D: begin
                            w_clrEn = 1'b1;
                            w_pushN = 2'd1;
                            w_push0 = {1'b0, ACK};
                        end
                        CH_S: begin
                            w_pushN = 2'd2;
                            w_push0 = {1'b0, STAT_HDR};
                            w_push1 = {1'b1, w_status};
                        end
                        default: begin
                            w_pushN = 2'd1;
                            w_push0 = {1'b0, NAK};
                            w_err   = 1'b1;
                        end
                    endcase
                end
            end
        end else begin
            if (bus.rxStrobe) begin
                w_stateNext = ST_IDLE;
                if (!w_qEmpty) begin
                    w_err = 1'b1;
                end else if (w_widthOk) begin
                    w_setWidth = 1'b1;
                    w_pushN    = 2'd1;
                    w_push0    = {1'b0, ACK};
                end else begin
                    w_pushN = 2'd1;
                    w_push0 = {1'b0, NAK};
                    w_err   = 1'b1;
                end
            end else if (r_cnt == CNT_LAST) begin
                w_stateNext = ST_IDLE;
                w_err       = 1'b1;
            end else begin
                w_cntInc = 1'b1;
            end
        end
    end

    // Blocking on our own pulse guarantees a gap between bytes handed to the UART.
    assign w_canIssue  = bus.txFree && !r_txTransmit;
    assign w_sendReply = w_canIssue && !w_qEmpty;
    assign w_sendPkt   = w_canIssue && w_qEmpty && r_traceEn && bus.pktReady;

    always_ff @(posedge clkOut) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_qCnt       <= 2'd0;
            r_ovfSticky  <= 1'b0;
            r_width      <= RESET_WIDTH;
            r_traceEn    <= 1'b1;
            r_txTransmit <= 1'b0;
            r_txByte     <= 8'h00;
            r_txIsStatus <= 1'b0;
            r_pktNext    <= 1'b0;
            r_cmdErr     <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_cntClr) begin
                r_cnt <= '0;
            end else if (w_cntInc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_pushN != 2'd0) begin
                r_qCnt <= w_pushN;
            end else if (w_sendReply) begin
                r_qCnt <= r_qCnt - 2'd1;
            end
            if (w_setEn) begin
                r_traceEn <= 1'b1;
            end else if (w_clrEn) begin
                r_traceEn <= 1'b0;
            end
            if (w_setWidth) begin
                r_width <= bus.rxByte[2:0];
            end
            if (bus.ovf) begin
                r_ovfSticky <= 1'b1;
            end else if (r_txTransmit && r_txIsStatus) begin
                r_ovfSticky <= 1'b0;
            end
            r_txTransmit <= w_sendReply || w_sendPkt;
            r_txIsStatus <= w_sendReply && r_q0[8];
            r_pktNext    <= w_sendPkt;
            r_cmdErr     <= w_err;
            if (w_sendReply) begin
                r_txByte <= r_q0[7:0];
            end else if (w_sendPkt) begin
                r_txByte <= bus.pktByte;
            end
        end
    end

    always_ff @(posedge clkOut) begin
        if (w_pushN != 2'd0) begin
            r_q0 <= w_push0;
            r_q1 <= w_push1;
        end else if (w_sendReply) begin
            r_q0 <= r_q1;
        end
    end

    assign bus.pktNext    = r_pktNext;
    assign bus.txTransmit = r_txTransmit;
    assign bus.txByte     = r_txByte;
    assign bus.width      = r_width;
    assign bus.traceEn    = r_traceEn;
    assign bus.cmdErr     = r_cmdErr;
endmodule

// File: tb/tb_trace_cmd_ctrl.sv
// Bench for trace_cmd_ctrl: directed command scenarios plus randomized traffic, all
// compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_trace_cmd_ctrl;
    localparam int TB_TIMEOUT = 48000;

    logic clkOut = 1'b0;
    logic rst    = 1'b1;
    always #5 clkOut = ~clkOut;

    trace_cmd_if bus();

    trace_cmd_ctrl #(.CMD_TIMEOUT(TB_TIMEOUT), .RESET_WIDTH(3'd4)) dut (
        .clkOut (clkOut),
        .rst    (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- observation of transmitted bytes and pulses ----------------
    logic [7:0] seen[$];
    int pkt_cnt = 0;
    int err_cnt = 0;

    always @(posedge clkOut) begin
        #1;
        if (bus.txTransmit === 1'b1) seen.push_back(bus.txByte);
        if (bus.pktNext === 1'b1) pkt_cnt++;
        if (bus.cmdErr === 1'b1) err_cnt++;
    end

    task automatic clear_obs();
        seen.delete();
        pkt_cnt = 0;
        err_cnt = 0;
    endtask

    function automatic logic [7:0] seen_at(input int i);
        if (i >= 0 && i < seen.size()) return seen[i];
        return 8'hxx;
    endfunction

    // ---------------- behavioural model ----------------
    // m_since_w: -1 when no 'W' argument is pending, else cycles already waited.
    bit         m_valid = 1'b0;
    int         m_since_w = -1;
    logic [8:0] m_rq[$];            // {is status, byte}
    logic       m_en = 1'b1, m_sticky = 1'b0;
    logic [2:0] m_width = 3'd4;
    logic       m_tx = 1'b0, m_tx_stat = 1'b0, m_pkt = 1'b0, m_err = 1'b0;
    logic [7:0] m_byte = 8'h00;

    bit         t_send_r, t_send_p, t_err;
    int         t_depth;
    logic [7:0] t_stat, t_b;
    logic [8:0] t_head;
    logic       t_en;
    logic [2:0] t_width;

    always @(posedge clkOut) begin
        if (rst) begin
            m_valid   = 1'b1;
            m_since_w = -1;
            m_rq.delete();
            m_en = 1'b1; m_sticky = 1'b0; m_width = 3'd4;
            m_tx = 1'b0; m_tx_stat = 1'b0; m_pkt = 1'b0; m_err = 1'b0; m_byte = 8'h00;
        end else begin
            t_send_r = 0; t_send_p = 0; t_err = 0; t_head = 9'h0;
            t_depth  = m_rq.size();
            t_stat   = {m_en, bus.sync, m_sticky, 2'b00, m_width};
            t_en     = m_en;
            t_width  = m_width;
            t_b      = bus.rxByte;
            if (bus.txFree && !m_tx) begin
                if (t_depth > 0) begin
                    t_send_r = 1;
                    t_head   = m_rq.pop_front();
                end else if (m_en && bus.pktReady) begin
                    t_send_p = 1;
                end
            end
            if (bus.rxErr) begin
                t_err = 1; m_since_w = -1;
            end else if (m_since_w < 0) begin
                if (bus.rxStrobe) begin
                    if (t_b == 8'h57) m_since_w = 0;
                    else if (t_depth > 0) t_err = 1;
                    else if (t_b == 8'h45) begin t_en = 1; m_rq.push_back({1'b0, 8'h06}); end
                    else if (t_b == 8'h44) begin t_en = 0; m_rq.push_back({1'b0, 8'h06}); end
                    else if (t_b == 8'h53) begin
                        m_rq.push_back({1'b0, 8'hA5});
                        m_rq.push_back({1'b1, t_stat});
                    end else begin
                        t_err = 1; m_rq.push_back({1'b0, 8'h15});
                    end
                end
            end else begin
                if (bus.rxStrobe) begin
                    m_since_w = -1;
                    if (t_depth > 0) t_err = 1;
                    else if (t_b == 8'd1 || t_b == 8'd2 || t_b == 8'd4) begin
                        t_width = t_b[2:0]; m_rq.push_back({1'b0, 8'h06});
                    end else begin
                        t_err = 1; m_rq.push_back({1'b0, 8'h15});
                    end
                end else if (m_since_w + 1 == TB_TIMEOUT) begin
                    t_err = 1; m_since_w = -1;
                end else begin
                    m_since_w++;
                end
            end
            if (bus.ovf) m_sticky = 1'b1;
            else if (m_tx && m_tx_stat) m_sticky = 1'b0;
            if (t_send_r) m_byte = t_head[7:0];
            else if (t_send_p) m_byte = bus.pktByte;
            m_tx      = t_send_r | t_send_p;
            m_tx_stat = t_send_r & t_head[8];
            m_pkt     = t_send_p;
            m_err     = t_err;
            m_en      = t_en;
            m_width   = t_width;
        end
    end

    always @(negedge clkOut) begin
        if (m_valid) begin
            check("txTransmit", 16'(bus.txTransmit), 16'(m_tx));
            check("txByte",     16'(bus.txByte),     16'(m_byte));
            check("pktNext",    16'(bus.pktNext),    16'(m_pkt));
            check("cmdErr",     16'(bus.cmdErr),     16'(m_err));
            check("width",      16'(bus.width),      16'(m_width));
            check("traceEn",    16'(bus.traceEn),    16'(m_en));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clkOut);
    endtask

    task automatic idle_pkt(input int n);
        repeat (n) begin
            bus.pktByte = 8'($urandom_range(63, 0));
            @(negedge clkOut);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rxByte   = b;
        bus.rxStrobe = 1'b1;
        @(negedge clkOut);
        bus.rxStrobe = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int ia;
        int n_a5;
        bus.rxStrobe = 0; bus.rxByte = 0; bus.rxErr = 0;
        bus.pktReady = 0; bus.pktByte = 0; bus.txFree = 1;
        bus.sync = 0; bus.ovf = 0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset_width",   16'(bus.width),      16'd4);
        check("reset_traceEn", 16'(bus.traceEn),    16'd1);
        check("reset_txTx",    16'(bus.txTransmit), 16'd0);
        check("reset_txByte",  16'(bus.txByte),     16'h00);
        check("reset_pktNext", 16'(bus.pktNext),    16'd0);
        check("reset_cmdErr",  16'(bus.cmdErr),     16'd0);

        // bad width argument is rejected
        clear_obs();
        send_rx(8'h57); send_rx(8'h03);
        idle(6);
        check("w03_width",   16'(bus.width),   16'd4);
        check("w03_errs",    16'(err_cnt),     16'd1);
        check("w03_nreply",  16'(seen.size()), 16'd1);
        check("w03_reply",   16'(seen_at(0)),  16'h15);

        // good width argument
        clear_obs();
        send_rx(8'h57); send_rx(8'h02);
        check("w02_width_next", 16'(bus.width), 16'd2);
        idle(6);
        check("w02_nreply", 16'(seen.size()), 16'd1);
        check("w02_reply",  16'(seen_at(0)),  16'h06);
        check("w02_errs",   16'(err_cnt),     16'd0);

        // sticky overflow appears once in status, then clears
        bus.sync = 1'b1;
        bus.ovf = 1'b1; idle(1); bus.ovf = 1'b0;
        idle(2);
        clear_obs();
        send_rx(8'h53); idle(8);
        check("s_ovf_n",    16'(seen.size()), 16'd2);
        check("s_ovf_hdr",  16'(seen_at(0)),  16'hA5);
        check("s_ovf_stat", 16'(seen_at(1)),  16'hE2);
        clear_obs();
        send_rx(8'h53); idle(8);
        check("s_clr_hdr",  16'(seen_at(0)),  16'hA5);
        check("s_clr_stat", 16'(seen_at(1)),  16'hC2);

        // status preempts streaming packets at a byte boundary
        clear_obs();
        bus.pktReady = 1'b1;
        idle_pkt(20);
        send_rx(8'h53);
        idle_pkt(20);
        bus.pktReady = 1'b0;
        idle(4);
        ia = -1; n_a5 = 0;
        foreach (seen[i]) if (seen[i] == 8'hA5) begin n_a5++; if (ia < 0) ia = i; end
        check("pre_hdr_count",  16'(n_a5), 16'd1);
        check("pre_pkts_before", 16'(ia > 0), 16'd1);
        check("pre_stat_next",  16'(seen_at(ia + 1)), 16'hC2);
        check("pre_resume",     16'(seen.size() > ia + 2), 16'd1);
        check("pre_pktnext",    16'(pkt_cnt), 16'(seen.size() - 2));

        // argument timeout
        clear_obs();
        send_rx(8'h57);
        idle(TB_TIMEOUT - 5);
        check("to_early_errs", 16'(err_cnt), 16'd0);
        idle(10);
        check("to_errs",   16'(err_cnt),     16'd1);
        check("to_silent", 16'(seen.size()), 16'd0);
        send_rx(8'h45); idle(5);
        check("to_e_ack",  16'(seen_at(0)),  16'h06);

        // disabled forwarding holds packets back
        clear_obs();
        send_rx(8'h44);
        bus.pktReady = 1'b1;
        idle_pkt(100);
        bus.pktReady = 1'b0;
        check("dis_pktnext", 16'(pkt_cnt),     16'd0);
        check("dis_ntx",     16'(seen.size()), 16'd1);
        check("dis_ack",     16'(seen_at(0)),  16'h06);

        // reset mid-command with a reply pending
        bus.txFree = 1'b0;
        send_rx(8'h45);
        send_rx(8'h57);
        rst = 1'b1;
        clear_obs();
        idle(1);
        rst = 1'b0;
        bus.txFree = 1'b1;
        idle(20);
        check("rst_width",   16'(bus.width),   16'd4);
        check("rst_traceEn", 16'(bus.traceEn), 16'd1);
        check("rst_ntx",     16'(seen.size()), 16'd0);
        check("rst_errs",    16'(err_cnt),     16'd0);

        // randomized traffic, checked by the model each cycle
        for (int c = 0; c < 4000; c++) begin
            bus.rxStrobe = ($urandom_range(7, 0) == 0);
            case ($urandom_range(9, 0))
                0: bus.rxByte = 8'h45;
                1: bus.rxByte = 8'h44;
                2, 3: bus.rxByte = 8'h53;
                4, 5: bus.rxByte = 8'h57;
                6: bus.rxByte = 8'd1;
                7: bus.rxByte = 8'd2;
                8: bus.rxByte = 8'd4;
                default: bus.rxByte = 8'($urandom);
            endcase
            bus.rxErr    = ($urandom_range(63, 0) == 0);
            bus.pktReady = 1'($urandom_range(1, 0));
            bus.pktByte  = 8'($urandom);
            bus.txFree   = ($urandom_range(3, 0) != 0);
            bus.sync     = 1'($urandom_range(1, 0));
            bus.ovf      = ($urandom_range(31, 0) == 0);
            rst          = ($urandom_range(511, 0) == 0);
            @(negedge clkOut);
        end
        bus.rxStrobe = 0; bus.rxErr = 0; rst = 0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
